// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, exception
// codes and controller state encodings.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

endpackage

// File: rtl/cp0_exc_ctrl_regs.sv
// CP0 register storage (SR, Cause, EPC) with exception commit, mtc0 write and
// mfc0 read muxing.
module cp0_regs
  import cp0_exc_ctrl_pkg::*;
#(
  parameter int          INT_W = 6,
  parameter logic [31:0] PRID  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INT_W-1:0] hwint,
  input  logic             take_exc,
  input  logic             take_int,
  input  logic             take_eret,
  input  logic             wr_en,
  input  logic [4:0]       addr,
  input  logic [4:0]       exccode,
  input  logic             bd,
  input  logic [31:0]      pc,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [31:0]      epc,
  output logic [INT_W-1:0] sr_im,
  output logic [INT_W-1:0] cause_ip,
  output logic             sr_exl,
  output logic             sr_ie
);

  logic       cause_bd;
  logic [4:0] cause_exc;
  logic       unused_pc_lo;

  assign unused_pc_lo = ^pc[1:0];

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] exc_epc(input logic [29:0] word, input logic in_bd);
    logic [31:0] base;
    base = {word, 2'b00};
    return in_bd ? base - 32'd4 : base;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_ip  <= '0;
      cause_bd  <= 1'b0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= hwint;
      if (take_exc) begin
        sr_exl    <= 1'b1;
        cause_exc <= take_int ? EXC_INT : exccode;
        cause_bd  <= bd;
        epc       <= exc_epc(pc[31:2], bd);
      end else begin
        if (wr_en) begin
          case (addr)
            CP0_SR: begin
              sr_im  <= wdata[SR_IM_LO +: INT_W];
              sr_exl <= wdata[SR_EXL];
              sr_ie  <= wdata[SR_IE];
            end
            CP0_EPC: epc <= {wdata[31:2], 2'b00};
            default: ;
          endcase
        end
        if (take_eret) sr_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      CP0_SR: begin
        rdata[SR_IM_LO +: INT_W] = sr_im;
        rdata[SR_EXL]            = sr_exl;
        rdata[SR_IE]             = sr_ie;
      end
      CP0_CAUSE: begin
        rdata[CAUSE_BD]              = cause_bd;
        rdata[CAUSE_IP_LO +: INT_W]  = cause_ip;
        rdata[CAUSE_EXC_LO +: 5]     = cause_exc;
      end
      CP0_EPC:  rdata = epc;
      CP0_PRID: rdata = PRID;
      default:  ;
    endcase
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: pending/priority logic,
// EXL sequencing and redirect requests around the cp0_regs storage.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter logic [31:0] PRID       = 32'h0000_0000,
  parameter int          INT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_m,
  input  logic             valid_m,
  input  logic [4:0]       exccode_m,
  input  logic             bd_m,
  input  logic             eret_m,
  input  logic             we_m,
  input  logic [4:0]       addr_m,
  input  logic [31:0]      wdata_m,
  input  logic [INT_W-1:0] hwint,
  output logic [31:0]      rdata,
  output logic             exc_req,
  output logic [31:0]      handler_pc,
  output logic             eret_req,
  output logic [31:0]      epc_out
);

  logic [INT_W-1:0] sr_im;
  logic [INT_W-1:0] cause_ip;
  logic             sr_exl;
  logic             sr_ie;
  logic [0:0]       state;
  logic             in_handler;
  logic             int_p;
  logic             exc_p;

  // The controller state is SR.EXL itself, so mtc0 to SR can move it too.
  assign state      = sr_exl ? ST_HANDLER : ST_RUN;
  assign in_handler = (state == ST_HANDLER);

  assign int_p    = (|(cause_ip & sr_im)) & sr_ie & !in_handler;
  assign exc_p    = valid_m & (exccode_m != EXC_INT) & !in_handler;
  assign exc_req  = !reset & (int_p | exc_p);
  assign eret_req = !reset & eret_m & valid_m & !exc_req;

  assign handler_pc = HANDLER_PC;

  cp0_regs #(
    .INT_W (INT_W),
    .PRID  (PRID)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .hwint     (hwint),
    .take_exc  (exc_req),
    .take_int  (int_p),
    .take_eret (eret_req),
    .wr_en     (we_m & valid_m),
    .addr      (addr_m),
    .exccode   (exccode_m),
    .bd        (bd_m),
    .pc        (pc_m),
    .wdata     (wdata_m),
    .rdata     (rdata),
    .epc       (epc_out),
    .sr_im     (sr_im),
    .cause_ip  (cause_ip),
    .sr_exl    (sr_exl),
    .sr_ie     (sr_ie)
  );

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: per-cycle stimulus tables push expected
// outputs, which are popped and compared at the falling edge.
module tb_cp0_exc_ctrl;
  import cp0_exc_ctrl_pkg::*;

  localparam logic [31:0] TB_PRID = 32'h0001_8001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        valid_m;
  logic [4:0]  exccode_m;
  logic        bd_m;
  logic        eret_m;
  logic        we_m;
  logic [4:0]  addr_m;
  logic [31:0] wdata_m;
  logic [5:0]  hwint;
  logic [31:0] rdata;
  logic        exc_req;
  logic [31:0] handler_pc;
  logic        eret_req;
  logic [31:0] epc_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(
    .HANDLER_PC (32'h0000_4180),
    .PRID       (TB_PRID),
    .INT_W      (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_m       (pc_m),
    .valid_m    (valid_m),
    .exccode_m  (exccode_m),
    .bd_m       (bd_m),
    .eret_m     (eret_m),
    .we_m       (we_m),
    .addr_m     (addr_m),
    .wdata_m    (wdata_m),
    .hwint      (hwint),
    .rdata      (rdata),
    .exc_req    (exc_req),
    .handler_pc (handler_pc),
    .eret_req   (eret_req),
    .epc_out    (epc_out)
  );

  typedef enum {O_RDATA, O_EXC, O_ERET, O_EPC} osel_t;
  typedef struct { osel_t sel; logic [31:0] val; } exp_t;
  typedef struct {
    logic rst, valid, bd, eret, we;
    logic [4:0] exc, addr;
    logic [31:0] wdata, pc;
    logic [5:0] hw;
    logic x_exc, x_eret, c_rd, c_epc;
    logic [31:0] x_rd, x_epc;
  } vec_t;

  exp_t sb[$];

  function automatic vec_t mk(input logic rst, input logic valid, input logic [4:0] exc,
                              input logic bd, input logic eret, input logic we,
                              input logic [4:0] addr, input logic [31:0] wdata,
                              input logic [31:0] pc, input logic [5:0] hw,
                              input logic x_exc, input logic x_eret,
                              input logic c_rd, input logic [31:0] x_rd,
                              input logic c_epc, input logic [31:0] x_epc);
    vec_t v;
    v.rst = rst; v.valid = valid; v.exc = exc; v.bd = bd; v.eret = eret; v.we = we;
    v.addr = addr; v.wdata = wdata; v.pc = pc; v.hw = hw;
    v.x_exc = x_exc; v.x_eret = x_eret; v.c_rd = c_rd; v.x_rd = x_rd;
    v.c_epc = c_epc; v.x_epc = x_epc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst; valid_m = v.valid; exccode_m = v.exc; bd_m = v.bd; eret_m = v.eret;
    we_m = v.we; addr_m = v.addr; wdata_m = v.wdata; pc_m = v.pc; hwint = v.hw;
    sb.push_back('{sel: O_EXC,  val: {31'd0, v.x_exc}});
    sb.push_back('{sel: O_ERET, val: {31'd0, v.x_eret}});
    if (v.c_rd)  sb.push_back('{sel: O_RDATA, val: v.x_rd});
    if (v.c_epc) sb.push_back('{sel: O_EPC,   val: v.x_epc});
  endtask

  function automatic logic [31:0] observe(input osel_t s);
    case (s)
      O_RDATA: return rdata;
      O_EXC:   return {31'd0, exc_req};
      O_ERET:  return {31'd0, eret_req};
      default: return epc_out;
    endcase
  endfunction

  task automatic test_reset();
    vec_t t[$]; exp_t e; logic [31:0] obs;
    t.push_back(mk(1'b1, 1'b1, EXC_INT, 1'b0, 1'b1, 1'b0, CP0_SR,    0, 32'h100, 6'd0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1'b1, 1'b1, EXC_RI,  1'b0, 1'b0, 1'b0, CP0_SR,    0, 32'h104, 6'd0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_SR,    0, 32'h108, 6'd0, 0, 0, 1, 0, 1, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_CAUSE, 0, 32'h10C, 6'd0, 0, 0, 1, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_EPC,   0, 32'h110, 6'd0, 0, 0, 1, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_PRID,  0, 32'h114, 6'd0, 0, 0, 1, TB_PRID, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, 5'd3,      0, 32'h118, 6'd0, 0, 0, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL reset step %0d %s: got 0x%08h want 0x%08h", i, e.sel.name(), obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (handler_pc !== 32'h0000_4180) begin
      errors++;
      $display("FAIL reset handler_pc: got 0x%08h want 0x00004180", handler_pc);
    end
  endtask

  task automatic test_interrupt();
    vec_t t[$]; exp_t e; logic [31:0] obs;
    t.push_back(mk(1'b0, 1'b1, EXC_INT, 1'b0, 1'b0, 1'b1, CP0_SR, 32'h401, 32'h1000, 6'd0, 0, 0, 1, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_SR, 0, 32'h1000, 6'd1, 0, 0, 1, 32'h401, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, 5'd0,   0, 32'h2000, 6'd1, 1, 0, 0, 0, 1, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_CAUSE, 0, 32'h2004, 6'd0, 0, 0, 1, 32'h400, 1, 32'h2000));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_EPC, 0, 32'h2008, 6'd0, 0, 0, 1, 32'h2000, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_SR,  0, 32'h200C, 6'd0, 0, 0, 1, 32'h403, 0, 0));
    t.push_back(mk(1'b0, 1'b1, EXC_INT, 1'b0, 1'b1, 1'b0, 5'd0,    0, 32'h4180, 6'd0, 0, 1, 0, 0, 1, 32'h2000));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_SR,  0, 32'h2000, 6'd0, 0, 0, 1, 32'h401, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL interrupt step %0d %s: got 0x%08h want 0x%08h", i, e.sel.name(), obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exception();
    vec_t t[$]; exp_t e; logic [31:0] obs;
    t.push_back(mk(1'b0, 1'b1, EXC_RI,  1'b1, 1'b0, 1'b0, 5'd0,      0, 32'h3010, 6'd0, 1, 0, 0, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b1, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_EPC,   0, 32'h3014, 6'd0, 0, 0, 1, 32'h300C, 1, 32'h300C));
    t.push_back(mk(1'b0, 1'b1, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_CAUSE, 0, 32'h3018, 6'd0, 0, 0, 1, 32'h8000_0028, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL exception step %0d %s: got 0x%08h want 0x%08h", i, e.sel.name(), obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exl_mask();
    vec_t t[$]; exp_t e; logic [31:0] obs;
    t.push_back(mk(1'b0, 1'b1, EXC_OV,  1'b0, 1'b0, 1'b0, 5'd0,      0, 32'h3018, 6'd1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b1, EXC_OV,  1'b0, 1'b0, 1'b0, CP0_CAUSE, 0, 32'h301C, 6'd0, 0, 0, 1, 32'h8000_0428, 0, 0));
    t.push_back(mk(1'b0, 1'b1, EXC_INT, 1'b0, 1'b1, 1'b0, 5'd0,      0, 32'h3020, 6'd0, 0, 1, 0, 0, 1, 32'h300C));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_SR,    0, 32'h300C, 6'd0, 0, 0, 1, 32'h401, 1, 32'h300C));
    t.push_back(mk(1'b0, 1'b1, EXC_INT, 1'b0, 1'b1, 1'b0, CP0_SR,    0, 32'h3100, 6'd0, 0, 1, 1, 32'h401, 1, 32'h300C));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL exl_mask step %0d %s: got 0x%08h want 0x%08h", i, e.sel.name(), obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mtc0_priority();
    vec_t t[$]; exp_t e; logic [31:0] obs;
    t.push_back(mk(1'b0, 1'b1, EXC_ADEL, 1'b0, 1'b0, 1'b1, CP0_EPC, 32'h1234, 32'h4000, 6'd0, 1, 0, 0, 0, 1, 32'h300C));
    t.push_back(mk(1'b0, 1'b0, EXC_INT,  1'b0, 1'b0, 1'b0, CP0_EPC, 0, 32'h4004, 6'd0, 0, 0, 1, 32'h4000, 1, 32'h4000));
    t.push_back(mk(1'b0, 1'b1, EXC_INT,  1'b0, 1'b1, 1'b0, 5'd0,    0, 32'h4008, 6'd0, 0, 1, 0, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b1, EXC_INT,  1'b0, 1'b0, 1'b1, CP0_EPC, 32'h5003, 32'h4008, 6'd0, 0, 0, 1, 32'h4000, 1, 32'h4000));
    t.push_back(mk(1'b0, 1'b0, EXC_INT,  1'b0, 1'b0, 1'b0, CP0_EPC, 0, 32'h400C, 6'd0, 0, 0, 1, 32'h5000, 1, 32'h5000));
    t.push_back(mk(1'b0, 1'b1, EXC_INT,  1'b0, 1'b0, 1'b1, CP0_CAUSE, 32'hFFFF_FFFF, 32'h4010, 6'd0, 0, 0, 1, 32'h10, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT,  1'b0, 1'b0, 1'b0, CP0_CAUSE, 0, 32'h4014, 6'd0, 0, 0, 1, 32'h10, 0, 0));
    t.push_back(mk(1'b0, 1'b1, EXC_INT,  1'b0, 1'b0, 1'b1, CP0_SR, 32'hFFFF_FFFF, 32'h4018, 6'd0, 0, 0, 1, 32'h401, 0, 0));
    t.push_back(mk(1'b0, 1'b1, EXC_INT,  1'b0, 1'b0, 1'b1, CP0_SR, 32'h401, 32'h401C, 6'd0, 0, 0, 1, 32'h0000_FC03, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT,  1'b0, 1'b0, 1'b0, CP0_SR, 0, 32'h4020, 6'd0, 0, 0, 1, 32'h401, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL mtc0_priority step %0d %s: got 0x%08h want 0x%08h", i, e.sel.name(), obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_int_over_exc();
    vec_t t[$]; exp_t e; logic [31:0] obs;
    t.push_back(mk(1'b0, 1'b0, EXC_RI,  1'b0, 1'b0, 1'b0, 5'd0,      0, 32'h6FF0, 6'd1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b1, EXC_RI,  1'b0, 1'b0, 1'b0, 5'd0,      0, 32'h7000, 6'd0, 1, 0, 0, 0, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_CAUSE, 0, 32'h7004, 6'd0, 0, 0, 1, 32'h0, 1, 32'h7000));
    t.push_back(mk(1'b0, 1'b1, EXC_INT, 1'b0, 1'b1, 1'b0, 5'd0,      0, 32'h7008, 6'd0, 0, 1, 0, 0, 1, 32'h7000));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL int_over_exc step %0d %s: got 0x%08h want 0x%08h", i, e.sel.name(), obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[$]; exp_t e; logic [31:0] obs;
    logic [31:0] prev;
    logic [31:0] d;
    prev = 32'h7000;
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      t.push_back(mk(1'b0, 1'b1, EXC_INT, 1'b0, 1'b0, 1'b1, CP0_EPC, d, 32'h8000 + 32'(k * 4), 6'd0,
                     0, 0, 1, prev, 1, prev));
      prev = {d[31:2], 2'b00};
    end
    t.push_back(mk(1'b0, 1'b0, EXC_INT, 1'b0, 1'b0, 1'b0, CP0_EPC, 0, 32'h8100, 6'd0, 0, 0, 1, prev, 1, prev));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL back_to_back step %0d %s: got 0x%08h want 0x%08h", i, e.sel.name(), obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_handler();
    vec_t t[$]; exp_t e; logic [31:0] obs;
    t.push_back(mk(1'b0, 1'b1, EXC_ADES, 1'b0, 1'b0, 1'b0, 5'd0,      0, 32'h6004, 6'd0, 1, 0, 0, 0, 0, 0));
    t.push_back(mk(1'b1, 1'b1, EXC_INT,  1'b0, 1'b1, 1'b0, 5'd0,      0, 32'h6008, 6'd1, 0, 0, 0, 0, 1, 32'h6004));
    t.push_back(mk(1'b0, 1'b0, EXC_INT,  1'b0, 1'b0, 1'b0, CP0_SR,    0, 32'h600C, 6'd1, 0, 0, 1, 32'h0, 1, 32'h0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT,  1'b0, 1'b0, 1'b0, CP0_CAUSE, 0, 32'h6010, 6'd0, 0, 0, 1, 32'h400, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT,  1'b0, 1'b0, 1'b0, CP0_EPC,   0, 32'h6014, 6'd0, 0, 0, 1, 32'h0, 0, 0));
    t.push_back(mk(1'b0, 1'b0, EXC_INT,  1'b0, 1'b0, 1'b0, CP0_CAUSE, 0, 32'h6018, 6'd0, 0, 0, 1, 32'h0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL reset_mid_handler step %0d %s: got 0x%08h want 0x%08h", i, e.sel.name(), obs, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pc_m = 32'd0; valid_m = 1'b0; exccode_m = 5'd0; bd_m = 1'b0;
    eret_m = 1'b0; we_m = 1'b0; addr_m = 5'd0; wdata_m = 32'd0; hwint = 6'd0;
    test_reset();
    test_interrupt();
    test_exception();
    test_exl_mask();
    test_mtc0_priority();
    test_int_over_exc();
    test_back_to_back();
    test_reset_mid_handler();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 register file plus exception/interrupt controller for the 5-stage MIPS pipeline.
- Sits at the M stage. It collects the exception code and branch-delay flag that travel down the pipeline from the decode/execute checkers, and arbitrates them against external hardware interrupts.
- When an exception or interrupt is taken it:
  - commits SR, Cause and EPC,
  - asserts a one-cycle flush/redirect to the handler,
  - sequences the handler back out on eret.

Parameters:
- HANDLER_PC, 32'h0000_4180, redirect target on any exception/interrupt.
- PRID, 32'h0000_0000, read-only value of register 15.
- INT_W, 6, number of hardware interrupt lines (Cause.IP / SR.IM width).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pc_m  in  32  PC of the instruction in M. The pipeline keeps this valid through bubbles.
- valid_m  in  1  M holds a real (non-bubble) instruction
- exccode_m  in  5  pipelined exception code; 0 means none
- bd_m  in  1  M instruction is in a branch delay slot
- eret_m  in  1  M instruction is eret
- we_m  in  1  M instruction is mtc0
- addr_m  in  5  CP0 register number (rd field)
- wdata_m  in  32  mtc0 data (forwarded rt)
- hwint  in  INT_W  external interrupt lines, level-sensitive
- rdata  out  32  mfc0 read data (combinational on addr_m)
- exc_req  out  1  take exception/interrupt this cycle; flush F/D/E/M, redirect to handler_pc
- handler_pc  out  32  constant HANDLER_PC
- eret_req  out  1  eret committing this cycle; redirect to epc_out
- epc_out  out  32  current EPC register

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; others 0.
  - EPC (14): 32 bits.
  - PRId (15): constant PRID.
  - Reads of any other address return 0.
- Reset (synchronous): SR=0, Cause=0, EPC=0. Outputs during reset: exc_req=0, eret_req=0.
- Cause.IP is loaded with hwint every cycle, so software sees a one-cycle delay.
- Interrupt pending: int_p = |(Cause.IP & SR.IM) & SR.IE & !SR.EXL. Uses the registered IP, so hwint-to-exc_req latency is 1 cycle.
- Exception pending: exc_p = valid_m & (exccode_m != 0) & !SR.EXL.
- exc_req = int_p | exc_p, combinational. Interrupt has priority over exception.
- Controller FSM follows SR.EXL:
  - RUN (EXL=0) -> HANDLER (EXL=1) on exc_req.
  - HANDLER -> RUN on eret_m & valid_m.
  - In HANDLER, exc_req is forced to 0. Nested exceptions are not supported; exccode_m is ignored.
- On exc_req, at the clock edge:
  - EXL<=1.
  - Cause.ExcCode <= int_p ? 0 : exccode_m.
  - Cause.BD <= bd_m.
  - EPC <= bd_m ? {pc_m[31:2],2'b00}-4 : {pc_m[31:2],2'b00}.
  - An interrupt taken on a bubble uses pc_m/bd_m as carried by the bubble.
- eret_req = eret_m & valid_m & !exc_req. At the edge: EXL<=0. eret in RUN still clears EXL and redirects.
- mtc0 (we_m & valid_m) writes the addressed register at the edge:
  - SR writes only IM/EXL/IE.
  - EPC writes {wdata[31:2],2'b00}.
  - Cause and PRId are not writable.
  - Suppressed if exc_req is asserted in the same cycle; exception state wins.
- mfc0 read-after-mtc0 in consecutive cycles sees the new value, since the register updates at the edge.
- Reset asserted mid-handler returns to RUN with all registers cleared in that cycle.

Decomposition:
- Shared header (existing global include): CP0 register numbers (SR 12, Cause 13, EPC 14, PRId 15), SR/Cause bit-field positions, ExcCode values (int 0, AdEL 4, AdES 5, RI 10, Ov 12), HANDLER_PC default.
- One natural sub-module, cp0_regs: SR/Cause/EPC storage with write/read muxing.
- cp0_exc_ctrl holds the pending/priority logic and EXL sequencing.

Test Plan:
- Reset, then addr_m=12/13/14/15 -> rdata 0, 0, 0, PRID; exc_req=0.
- mtc0 SR=0x0000_0401, hwint=6'b000001 -> exc_req=1 on the cycle after hwint rises. Next cycle: Cause.ExcCode=0, EXL=1, EPC=pc_m.
- valid_m=1, exccode_m=10, bd_m=1, pc_m=0x3010 -> exc_req=1; then EPC=0x300C, Cause=0x8000_0028.
- EXL=1 with exccode_m=12 or hwint active -> exc_req stays 0. eret_m=1 -> eret_req=1, epc_out unchanged, EXL=0 next cycle.
- Same cycle: exccode_m=4 and mtc0 to EPC=0x1234 -> EPC=pc_m, not 0x1234. mtc0 EPC=0x5003 alone -> EPC=0x5000.
- Reset asserted while EXL=1 -> SR=Cause=EPC=0 next cycle; hwint with SR=0 produces no exc_req.
